// File: rtl/vpu_pkg.sv
`default_nettype none
// ============================================================================
// Package : vpu_pkg
// Purpose : Shared vector-unit definitions: sequencer state encoding,
//           vector memory opcodes and the default element stride.
// Revision: 1.0 - initial release
// ============================================================================
package vpu_pkg;

  // Sequencer state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_FIN   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_FIN   = ST_FIN
  } vseq_state_e;

  // Major opcodes of the vector memory instructions
  localparam logic [6:0] OPC_LW_V = 7'b0000111;
  localparam logic [6:0] OPC_SW_V = 7'b0100111;

  // Byte distance between consecutive vector elements
  localparam int ELEM_BYTES_DEF = 4;

endpackage : vpu_pkg
`default_nettype wire

// File: rtl/vmem_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : vmem_sequencer
// Purpose : Breaks LW_V / SW_V into VLEN element accesses on the shared data
//           memory, stalls the pipeline while busy and writes an assembled
//           load vector to the vector register file in one strobe.
// Revision: 1.0 - initial release
// ============================================================================
module vmem_sequencer
  import vpu_pkg::*;
#(
  parameter int VLEN       = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int ELEM_BYTES = ELEM_BYTES_DEF,
  parameter int VREG_AW    = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     is_store,
  input  logic [ADDR_W-1:0]        base_addr,
  input  logic [VREG_AW-1:0]       vd,
  input  logic [VLEN*DATA_W-1:0]   vs_data,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     vreg_we,
  output logic [VREG_AW-1:0]       vreg_waddr,
  output logic [VLEN*DATA_W-1:0]   vreg_wdata,
  output logic                     busy,
  output logic                     stall,
  output logic                     done
);

  localparam int IDX_W = (VLEN > 1) ? $clog2(VLEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VLEN - 1);

  vseq_state_e        state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               op_store;
  logic [ADDR_W-1:0]  base_q;
  logic [VREG_AW-1:0] vd_q;
  logic [DATA_W-1:0]  st_lane [VLEN];
  logic [DATA_W-1:0]  ld_lane [VLEN];
  logic [VLEN*DATA_W-1:0] ld_vec_next;

  // Element address; the sum wraps modulo 2^ADDR_W on purpose
  function automatic logic [ADDR_W-1:0] elem_addr(input logic [ADDR_W-1:0] b,
                                                  input logic [IDX_W-1:0]  i);
    return b + ADDR_W'(i) * ADDR_W'(ELEM_BYTES);
  endfunction

  assign idx_nxt = idx + IDX_W'(1);

  // Upstream must freeze in the very cycle a vector op is presented
  assign stall = busy | start;

  // Load buffer including the lane arriving this cycle, used for the final write
  always_comb begin
    ld_vec_next = '0;
    for (int i = 0; i < VLEN; i++) begin
      ld_vec_next[i*DATA_W +: DATA_W] = (IDX_W'(i) == idx) ? mem_rdata : ld_lane[i];
    end
  end

  // Sequencer FSM with registered (Moore) outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      op_store   <= 1'b0;
      base_q     <= '0;
      vd_q       <= '0;
      for (int i = 0; i < VLEN; i++) begin
        st_lane[i] <= '0;
        ld_lane[i] <= '0;
      end
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      vreg_we    <= 1'b0;
      vreg_waddr <= '0;
      vreg_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done    <= 1'b0;
      vreg_we <= 1'b0;
      case (state)
        S_IDLE: begin
          // start arriving while busy never reaches here, so it is ignored
          if (start) begin
            op_store <= is_store;
            base_q   <= base_addr;
            vd_q     <= vd;
            for (int i = 0; i < VLEN; i++) begin
              st_lane[i] <= vs_data[i*DATA_W +: DATA_W];
            end
            idx       <= '0;
            state     <= S_ISSUE;
            busy      <= 1'b1;
            mem_req   <= 1'b1;
            mem_we    <= is_store;
            mem_addr  <= base_addr;
            mem_wdata <= vs_data[DATA_W-1:0];
          end
        end

        S_ISSUE: begin
          // Without a grant every request output simply holds its value
          if (mem_gnt) begin
            if (op_store && (idx != LAST_IDX)) begin
              idx       <= idx_nxt;
              mem_addr  <= elem_addr(base_q, idx_nxt);
              mem_wdata <= st_lane[idx_nxt];
            end else begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_addr  <= '0;
              mem_wdata <= '0;
              if (op_store) begin
                state <= S_FIN;
                done  <= 1'b1;
              end else begin
                state <= S_WAIT;
              end
            end
          end
        end

        S_WAIT: begin
          if (mem_rvalid) begin
            ld_lane[idx] <= mem_rdata;
            if (idx == LAST_IDX) begin
              state      <= S_FIN;
              done       <= 1'b1;
              vreg_we    <= 1'b1;
              vreg_waddr <= vd_q;
              vreg_wdata <= ld_vec_next;
            end else begin
              idx       <= idx_nxt;
              state     <= S_ISSUE;
              mem_req   <= 1'b1;
              mem_we    <= op_store;
              mem_addr  <= elem_addr(base_q, idx_nxt);
              mem_wdata <= st_lane[idx_nxt];
            end
          end
        end

        S_FIN: begin
          state      <= S_IDLE;
          busy       <= 1'b0;
          vreg_waddr <= '0;
          vreg_wdata <= '0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : vmem_sequencer
`default_nettype wire

// File: tb/tb_vmem_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_vmem_sequencer
// Purpose : Scoreboard bench for vmem_sequencer with a small memory responder.
// Revision: 1.0 - initial release
// ============================================================================
module tb_vmem_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_store;
  logic [31:0]  base_addr;
  logic [4:0]   vd;
  logic [127:0] vs_data;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;
  logic         vreg_we;
  logic [4:0]   vreg_waddr;
  logic [127:0] vreg_wdata;
  logic         busy;
  logic         stall;
  logic         done;

  vmem_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .is_store   (is_store),
    .base_addr  (base_addr),
    .vd         (vd),
    .vs_data    (vs_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .vreg_we    (vreg_we),
    .vreg_waddr (vreg_waddr),
    .vreg_wdata (vreg_wdata),
    .busy       (busy),
    .stall      (stall),
    .done       (done)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic [4:0]   waddr;
    logic [127:0] wdata;
  } vreg_exp_t;

  mem_exp_t  mq[$];
  vreg_exp_t vq[$];
  int        dq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Memory responder state
  logic [31:0] rd_tab [4];
  int          rd_idx;
  int          req_cnt;
  int          hold_elem;
  int          hold_left;
  bit          spur_arm;
  bit          pend_load;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Memory model: grants unless a hold is armed, returns load data one cycle after grant
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      pend_load  = 1'b0;
    end else begin
      mem_rvalid = 1'b0;
      if (pend_load) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rd_tab[rd_idx % 4];
        rd_idx++;
      end else if (spur_arm && mem_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEADBEEF;
        spur_arm   = 1'b0;
      end
      mem_gnt = 1'b0;
      if (mem_req) begin
        if (hold_left > 0 && req_cnt == hold_elem) begin
          hold_left--;
        end else begin
          mem_gnt = 1'b1;
          req_cnt++;
        end
      end
      pend_load = mem_gnt && !mem_we;
    end
  end

  // Monitor: compares DUT outputs against the scoreboard queues
  always @(negedge clk) begin
    #2;
    if (rst_n) begin
      if (mem_req) begin
        chk("stall_during_req", {127'd0, stall}, 128'd1);
        if (mq.size() == 0) begin
          chk("unexpected_mem_req", 128'd1, 128'd0);
        end else begin
          chk("mem_addr", {96'd0, mem_addr}, {96'd0, mq[0].addr});
          chk("mem_we", {127'd0, mem_we}, {127'd0, mq[0].we});
          if (mq[0].we) chk("mem_wdata", {96'd0, mem_wdata}, {96'd0, mq[0].wdata});
          if (mem_gnt) void'(mq.pop_front());
        end
      end
      if (vreg_we) begin
        chk("vreg_we_with_done", {127'd0, done}, 128'd1);
        if (vq.size() == 0) begin
          chk("unexpected_vreg_we", 128'd1, 128'd0);
        end else begin
          vreg_exp_t v;
          v = vq.pop_front();
          chk("vreg_waddr", {123'd0, vreg_waddr}, {123'd0, v.waddr});
          chk("vreg_wdata", vreg_wdata, v.wdata);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          chk("unexpected_done", 128'd1, 128'd0);
        end else begin
          int e;
          e = dq.pop_front();
          chk("done_cycle", 128'(cyc), 128'(e));
        end
      end
    end
  end

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_mem_req"},    {127'd0, mem_req},   128'd0);
    chk({tag, "_mem_we"},     {127'd0, mem_we},    128'd0);
    chk({tag, "_mem_addr"},   {96'd0, mem_addr},   128'd0);
    chk({tag, "_mem_wdata"},  {96'd0, mem_wdata},  128'd0);
    chk({tag, "_vreg_we"},    {127'd0, vreg_we},   128'd0);
    chk({tag, "_vreg_waddr"}, {123'd0, vreg_waddr}, 128'd0);
    chk({tag, "_vreg_wdata"}, vreg_wdata,          128'd0);
    chk({tag, "_busy"},       {127'd0, busy},      128'd0);
    chk({tag, "_stall"},      {127'd0, stall},     128'd0);
    chk({tag, "_done"},       {127'd0, done},      128'd0);
  endtask

  // One vector operation: push expectations, pulse start, optionally disturb, wait for idle
  task automatic run_op(input logic st, input logic [31:0] base, input logic [4:0] vdi,
                        input logic [127:0] vsv, input logic [127:0] rdv,
                        input int hold_e, input int hold_n, input int inj_at,
                        input bit spur, input int abort_at, input int done_off);
    int t0;
    int n_el;
    int budget;
    mem_exp_t m;
    vreg_exp_t v;
    n_el = (abort_at > 0) ? 3 : 4;
    for (int i = 0; i < n_el; i++) begin
      m.we    = st;
      m.addr  = base + 32'(4 * i);
      m.wdata = vsv[i*32 +: 32];
      mq.push_back(m);
    end
    for (int i = 0; i < 4; i++) rd_tab[i] = rdv[i*32 +: 32];
    rd_idx    = 0;
    req_cnt   = 0;
    hold_elem = hold_e;
    hold_left = hold_n;
    spur_arm  = spur;

    @(negedge clk);
    t0 = cyc;
    if (abort_at == 0) begin
      dq.push_back(t0 + done_off);
      if (!st) begin
        v.waddr = vdi;
        v.wdata = rdv;
        vq.push_back(v);
      end
    end
    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    vd        = vdi;
    vs_data   = vsv;
    #1;
    chk("stall_on_start", {127'd0, stall}, 128'd1);
    @(negedge clk);
    start     = 1'b0;
    base_addr = 32'h0;
    vs_data   = 128'h0;

    budget = 0;
    while (budget < 60) begin
      if (abort_at > 0 && cyc == t0 + abort_at) begin
        #3;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        break;
      end
      if (inj_at > 0 && cyc == t0 + inj_at) begin
        start     = 1'b1;
        is_store  = ~st;
        base_addr = 32'h0000_0999;
        vd        = 5'd30;
        vs_data   = {4{32'h5555_AAAA}};
        #1;
        chk("stall_start_while_busy", {127'd0, stall}, 128'd1);
        @(negedge clk);
        start     = 1'b0;
        base_addr = 32'h0;
        vs_data   = 128'h0;
        budget++;
        continue;
      end
      if (cyc > t0 + 1 && !busy) break;
      @(negedge clk);
      budget++;
    end
    if (budget >= 60) chk("op_timeout", 128'd1, 128'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    is_store  = 1'b0;
    base_addr = 32'h0;
    vd        = 5'd0;
    vs_data   = 128'h0;
    mem_gnt   = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    rd_idx    = 0;
    req_cnt   = 0;
    hold_elem = 0;
    hold_left = 0;
    spur_arm  = 1'b0;
    pend_load = 1'b0;
    for (int i = 0; i < 4; i++) rd_tab[i] = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);

    // 1: load, ideal memory
    run_op(1'b0, 32'h0000_0100, 5'd3, 128'h0,
           128'h000000A3_000000A2_000000A1_000000A0, 0, 0, 0, 1'b0, 0, 9);
    // 2: store, ideal memory
    run_op(1'b1, 32'h0000_0200, 5'd0,
           128'h000000D3_000000D2_000000D1_000000D0, 128'h0, 0, 0, 0, 1'b0, 0, 5);
    // 3: store, grant withheld 3 cycles on element 1
    run_op(1'b1, 32'h0000_0200, 5'd0,
           128'h000000D3_000000D2_000000D1_000000D0, 128'h0, 1, 3, 0, 1'b0, 0, 8);
    // 4: load with address wrap
    run_op(1'b0, 32'hFFFF_FFF8, 5'd1, 128'h0,
           128'h000000B3_000000B2_000000B1_000000B0, 0, 0, 0, 1'b0, 0, 9);
    // 5: reset while waiting on element 2, then a fresh load
    run_op(1'b0, 32'h0000_0400, 5'd9, 128'h0,
           128'h000000C3_000000C2_000000C1_000000C0, 0, 0, 0, 1'b0, 6, 9);
    #1;
    check_outputs_zero("post_abort");
    run_op(1'b0, 32'h0000_0300, 5'd7, 128'h0,
           128'h000000E3_000000E2_000000E1_000000E0, 0, 0, 0, 1'b0, 0, 9);
    // 6: start while busy and a spurious rvalid in ISSUE
    run_op(1'b0, 32'h0000_0100, 5'd3, 128'h0,
           128'h000000A3_000000A2_000000A1_000000A0, 0, 0, 3, 1'b1, 0, 9);

    repeat (3) @(negedge clk);
    #3;
    chk("mem_queue_drained",  128'(mq.size()), 128'd0);
    chk("vreg_queue_drained", 128'(vq.size()), 128'd0);
    chk("done_queue_drained", 128'(dq.size()), 128'd0);
    chk("idle_at_end", {127'd0, busy}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_vmem_sequencer
`default_nettype wire
